// File: rtl/inverse_lerp_pkg.sv
// Shared types for the inverse_lerp block.
//   ratio_flags_t : status flags returned alongside each ratio.
package inverse_lerp_pkg;

  // Result qualifiers; at most one is set per result, degenerate wins.
  typedef struct packed {
    logic clamped;
    logic degenerate;
  } ratio_flags_t;

endpackage

// File: rtl/inverse_lerp_frac_divider.sv
// Restoring fractional divider: quotient = floor(num * 2^ITERS / den), num < den.
//   clk, reset : clock, synchronous active-high reset (aborts a divide)
//   start_i    : load num_i/den_i and begin ITERS iterations
//   num_i      : dividend, must be < den_i
//   den_i      : divisor, non-zero
//   last_c_o   : current cycle performs the final iteration
//   quo_c_o    : quotient including this cycle's bit (complete when last_c_o)
module inverse_lerp_frac_divider
  import inverse_lerp_pkg::*;
#(
  parameter int unsigned NUM_BITS = 17,
  parameter int unsigned ITERS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic [NUM_BITS-1:0] num_i,
  input  logic [NUM_BITS-1:0] den_i,
  output logic                last_c_o,
  output logic [ITERS-1:0]    quo_c_o
);

  localparam int unsigned CNT_BITS = $clog2(ITERS + 1);

  logic [NUM_BITS-1:0] rem_q, rem_d;
  logic [NUM_BITS-1:0] den_q, den_d;
  logic [NUM_BITS-1:0] rem_sh;
  logic [ITERS-1:0]    quo_q, quo_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                qbit;

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  // One quotient bit per cycle, MSB first. rem < den keeps the shifted
  // remainder inside NUM_BITS, so no carry bit is lost by the shift.
  always_comb begin
    rem_d    = rem_q;
    den_d    = den_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    rem_sh   = rem_q << 1;
    qbit     = (rem_sh >= den_q);
    quo_c_o  = (quo_q << 1) | ITERS'(qbit);
    last_c_o = (cnt_q == CNT_BITS'(1));
    if (start_i) begin
      rem_d = num_i;
      den_d = den_i;
      quo_d = '0;
      cnt_d = CNT_BITS'(ITERS);
    end else if (cnt_q != '0) begin
      rem_d = qbit ? (rem_sh - den_q) : rem_sh;
      quo_d = quo_c_o;
      cnt_d = cnt_q - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/inverse_lerp.sv
// Inverse lerp: ratio = floor((x-a) * 2^RATIO_FRAC_BITS / (b-a)), saturated,
// oriented so ratio grows from a towards b.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : request handshake carrying a, b, x
//   a, b, x              : endpoints and sample (unsigned)
//   out_valid/out_ready  : result handshake
//   ratio                : unsigned 0.RATIO_FRAC_BITS fraction
//   clamped, degenerate  : x outside [a,b) / a == b
module inverse_lerp
  import inverse_lerp_pkg::*;
#(
  parameter int unsigned INPUT_BITS      = 16,
  parameter int unsigned RATIO_FRAC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INPUT_BITS-1:0]      a,
  input  logic [INPUT_BITS-1:0]      b,
  input  logic [INPUT_BITS-1:0]      x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RATIO_FRAC_BITS-1:0] ratio,
  output logic                       clamped,
  output logic                       degenerate
);

  localparam int unsigned DW = INPUT_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [INPUT_BITS-1:0]      a_q, a_d, b_q, b_d, x_q, x_d;
  logic [RATIO_FRAC_BITS-1:0] ratio_q, ratio_d;
  ratio_flags_t               flags_q, flags_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [DW-1:0]       num_c, den_c;
  logic                       div_start_c, div_last_c;
  logic [RATIO_FRAC_BITS-1:0] div_quo_c;

  assign in_ready   = (state_q == S_IDLE) && !reset;
  assign out_valid  = out_valid_q;
  assign ratio      = ratio_q;
  assign clamped    = flags_q.clamped;
  assign degenerate = flags_q.degenerate;

  // Orient the span so den >= 0; num goes negative when x lies behind a.
  always_comb begin
    if (b_q >= a_q) begin
      num_c = $signed({1'b0, x_q}) - $signed({1'b0, a_q});
      den_c = $signed({1'b0, b_q}) - $signed({1'b0, a_q});
    end else begin
      num_c = $signed({1'b0, a_q}) - $signed({1'b0, x_q});
      den_c = $signed({1'b0, a_q}) - $signed({1'b0, b_q});
    end
  end

  inverse_lerp_frac_divider #(
    .NUM_BITS (DW),
    .ITERS    (RATIO_FRAC_BITS)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start_i  (div_start_c),
    .num_i    ($unsigned(num_c)),
    .den_i    ($unsigned(den_c)),
    .last_c_o (div_last_c),
    .quo_c_o  (div_quo_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      ratio_q     <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      ratio_q     <= ratio_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    ratio_d     = ratio_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    div_start_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          x_d     = x;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        // Early-out cases skip the divider; degenerate is checked first.
        if (den_c == '0) begin
          ratio_d     = '0;
          flags_d     = '{clamped: 1'b0, degenerate: 1'b1};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (num_c < 0) begin
          ratio_d     = '0;
          flags_d     = '{clamped: 1'b1, degenerate: 1'b0};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (num_c >= den_c) begin
          ratio_d     = '1;
          flags_d     = '{clamped: 1'b1, degenerate: 1'b0};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          div_start_c = 1'b1;
          state_d     = S_DIV;
        end
      end
      S_DIV: begin
        if (div_last_c) begin
          ratio_d     = div_quo_c;
          flags_d     = '0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inverse_lerp.sv
// Self-checking bench for inverse_lerp: directed vectors, backpressure,
// reset abort, random sweep, plus a wide (24-bit / 37-frac) instance.
module tb_inverse_lerp;

  localparam int unsigned IB  = 16;
  localparam int unsigned RF  = 8;
  localparam int unsigned IBW = 24;
  localparam int unsigned RFW = 37;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready, clamped, degenerate;
  logic [IB-1:0] a, b, x;
  logic [RF-1:0] ratio;

  logic in_valid_w, in_ready_w, out_valid_w, out_ready_w, clamped_w, degenerate_w;
  logic [IBW-1:0] aw, bw, xw;
  logic [RFW-1:0] ratio_w;

  always #5 clk = ~clk;

  inverse_lerp #(.INPUT_BITS(IB), .RATIO_FRAC_BITS(RF)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .ratio(ratio), .clamped(clamped), .degenerate(degenerate)
  );

  inverse_lerp #(.INPUT_BITS(IBW), .RATIO_FRAC_BITS(RFW)) u_dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(aw), .b(bw), .x(xw), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .ratio(ratio_w), .clamped(clamped_w), .degenerate(degenerate_w)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;

  typedef struct {
    longint unsigned ratio;
    bit              cl;
    bit              dg;
    int              lat;
    int              acc_cyc;
    bit              seen;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   rst_seen;
  bit   hs_prev;

  // Reference: plain integer arithmetic on the definition of the ratio.
  function automatic exp_t model(input longint av, input longint bv, input longint xv,
                                 input int fb);
    exp_t   e;
    longint num, den;
    e = '{ratio: 0, cl: 0, dg: 0, lat: 2, acc_cyc: 0, seen: 0};
    if (av == bv) begin
      e.dg = 1;
    end else begin
      if (bv > av) begin num = xv - av; den = bv - av; end
      else         begin num = av - xv; den = av - bv; end
      if (num < 0) begin
        e.cl = 1;
      end else if (num >= den) begin
        e.cl    = 1;
        e.ratio = (64'd1 << fb) - 64'd1;
      end else begin
        e.ratio = $unsigned((num <<< fb) / den);
        e.lat   = fb + 2;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
  endtask

  // Single compare process for the main DUT.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("in_ready_during_reset", 64'(in_ready), 64'd0);
      exp_q.delete();
      rst_seen = 1;
      hs_prev  = 0;
    end else begin
      if (rst_seen) begin
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ratio", 64'(ratio), 64'd0);
        check("rst_flags", 64'({clamped, degenerate}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_seen = 0;
      end
      if (hs_prev) check("in_ready_after_handshake", 64'(in_ready), 64'd1);
      hs_prev = 0;
      if (out_valid) begin
        check("in_ready_while_valid", 64'(in_ready), 64'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          if (!exp_q[0].seen) begin
            check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
            exp_q[0].seen = 1;
          end
          check("ratio", 64'(ratio), exp_q[0].ratio);
          check("clamped", 64'(clamped), 64'(exp_q[0].cl));
          check("degenerate", 64'(degenerate), 64'(exp_q[0].dg));
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_prev = 1;
          end
        end
      end
      if (in_valid && in_ready) begin
        mon_e = model(64'(a), 64'(b), 64'(x), RF);
        mon_e.acc_cyc = cyc;
        exp_q.push_back(mon_e);
      end
    end
  end

  // Consumer readiness: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [IB-1:0] av, input logic [IB-1:0] bv, input logic [IB-1:0] xv);
    int n;
    @(posedge clk); #1;
    a = av; b = bv; x = xv; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(in_valid && in_ready) && n < 300);
    if (n >= 300) fail_now("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = IB'($urandom); b = IB'($urandom); x = IB'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) fail_now("drain_timeout");
  endtask

  // Pins the model to hand-computed values, then runs the vector on the DUT.
  task automatic directed(input logic [IB-1:0] av, input logic [IB-1:0] bv,
                          input logic [IB-1:0] xv, input logic [63:0] er,
                          input bit ecl, input bit edg, input int elat);
    exp_t e;
    e = model(64'(av), 64'(bv), 64'(xv), RF);
    check("model_ratio", e.ratio, er);
    check("model_clamped", 64'(e.cl), 64'(ecl));
    check("model_degenerate", 64'(e.dg), 64'(edg));
    check("model_latency", 64'(e.lat), 64'(elat));
    send(av, bv, xv);
    drain();
  endtask

  task automatic run_wide(input logic [IBW-1:0] av, input logic [IBW-1:0] bv,
                          input logic [IBW-1:0] xv);
    exp_t e;
    int   n;
    e = model(64'(av), 64'(bv), 64'(xv), RFW);
    @(posedge clk); #1;
    aw = av; bw = bv; xw = xv; in_valid_w = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready_w && n < 100);
    if (n >= 100) fail_now("wide_accept_timeout");
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid_w && n < 200);
    if (!out_valid_w) begin
      fail_now("wide_result_timeout");
    end else begin
      check("wide_latency", 64'(n), 64'(e.lat));
      check("wide_ratio", 64'(ratio_w), e.ratio);
      check("wide_flags", 64'({clamped_w, degenerate_w}), 64'({e.cl, e.dg}));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [IB-1:0]  ra, rb, rx;
    logic [IBW-1:0] wa, wb, wx;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; x = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b1; aw = '0; bw = '0; xw = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    directed(16'h0000, 16'hFFFF, 16'h7FFF, 64'h7F, 0, 0, 10);
    directed(16'h0000, 16'hFFFF, 16'h8000, 64'h80, 0, 0, 10);
    directed(16'hFFFF, 16'h0000, 16'h7FFF, 64'h80, 0, 0, 10);
    directed(16'hFFFF, 16'h0000, 16'hFFFF, 64'h00, 0, 0, 10);
    directed(16'hFFFF, 16'h0000, 16'h0000, 64'hFF, 1, 0, 2);
    directed(16'h1000, 16'h2000, 16'h1800, 64'h80, 0, 0, 10);
    directed(16'h1000, 16'h2000, 16'h2000, 64'hFF, 1, 0, 2);
    directed(16'h1000, 16'h2000, 16'h0800, 64'h00, 1, 0, 2);
    directed(16'h1234, 16'h1234, 16'h5678, 64'h00, 0, 1, 2);
    directed(16'h5555, 16'h5555, 16'h5555, 64'h00, 0, 1, 2);
    directed(16'h1000, 16'h2000, 16'h1000, 64'h00, 0, 0, 10);

    // Backpressure: result must hold while stalled, request pulses ignored.
    rdy_mode = 2;
    send(16'h0000, 16'hFFFF, 16'h1234);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) fail_now("bp_result_timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0);
      a = IB'($urandom); b = IB'($urandom); x = IB'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // Reset during the third divide cycle aborts the operation.
    send(16'h0000, 16'hFFFF, 16'h1234);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    directed(16'h0000, 16'hFFFF, 16'h4000, 64'h40, 0, 0, 10);

    // Random sweep with random consumer stalls.
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      ra = IB'($urandom); rb = IB'($urandom); rx = IB'($urandom);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rx = ra;
        2: rx = rb;
        3: begin
          ra = IB'($urandom_range(0, 255));
          rb = ra + IB'($urandom_range(1, 3));
          rx = ra + IB'($urandom_range(0, 4));
        end
        default: ;
      endcase
      send(ra, rb, rx);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    rdy_mode = 0;

    // Wide configuration.
    run_wide(24'h000000, 24'hFFFFFF, 24'h800000);
    run_wide(24'hFFFFFF, 24'h000000, 24'h000001);
    run_wide(24'h123456, 24'h123456, 24'h000000);
    run_wide(24'h100000, 24'h200000, 24'h300000);
    for (int i = 0; i < 40; i++) begin
      wa = IBW'($urandom); wb = IBW'($urandom); wx = IBW'($urandom);
      if ($urandom_range(0, 4) == 0) wx = wa;
      run_wide(wa, wb, wx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
